sn_to_bn_counter: RTL and testbench
===================================

Name: sn_to_bn_counter

Overview:
- Downstream stage of the 4-lane stochastic bit-stream generator.
- Consumes the generator's per-lane bit streams plus its "generating" flag.
- Counts ones per lane over one stream window (up to 16 cycles) and converts back to binary: per-lane counts and a lane sum.
- Presents results to the next stage on a valid/ready handshake, holding them until accepted.

Parameters:
- LANES, 4, number of stochastic lanes.
- WIN, 16, maximum window length in cycles.
- CW, 5, per-lane count width, equal to $clog2(WIN+1).
- SW, 7, sum width, equal to $clog2(LANES*WIN+1).

Ports:
- i_clk_sn2bn  in  1  clock; all state updates on its rising edge.
- i_rst_n_sn2bn  in  1  asynchronous, active-low reset.
- i_isgen  in  1  upstream generating flag; high while stream bits are valid.
- i_sn_bit  in  1 x LANES (unpacked)  stream bit per lane.
- i_ready  in  1  downstream accepts the result this cycle.
- o_valid  out  1  result registers hold a complete window.
- o_lane_cnt  out  CW x LANES (unpacked)  ones count per lane.
- o_sum  out  SW  sum of all lane counts.
- o_len  out  CW  number of cycles counted in the window (1..WIN).
- o_overrun  out  1  sticky flag: a window started while the previous result was unaccepted.

Behaviour:
- Reset (asynchronous, i_rst_n_sn2bn low):
  - State goes to IDLE.
  - o_valid, o_lane_cnt, o_sum, o_len and o_overrun all go to 0.
  - Internal accumulators and the registered copy of i_isgen go to 0.
  - Reset mid-window discards the partial window; no o_valid is produced for it.
- Start detection: start = i_isgen & ~isgen_d, where isgen_d is i_isgen registered. A window only opens on a rising edge.
- States:
  - IDLE: on start, go to ACC.
    - Accumulators load the start-cycle bits (acc[k] = i_sn_bit[k]); length counter = 1.
    - If WIN = 1, go straight to DONE processing.
  - ACC: while i_isgen is high and len < WIN, acc[k] += i_sn_bit[k] and len += 1.
    - The window closes when i_isgen is low (that cycle's bits are not counted), or when the cycle that made len = WIN has been counted.
    - On close, the result registers load: o_lane_cnt = acc, o_sum = sum of acc, o_len = len. o_valid = 1 from the next cycle. Go to HOLD.
    - Latency: o_valid rises 1 cycle after the last counted bit.
  - HOLD: o_valid = 1 and outputs are stable.
    - On i_ready = 1, the result is transferred; o_valid = 0 the next cycle; go to IDLE.
    - A start in the same cycle as i_ready is accepted: go to ACC and load the start-cycle bits.
    - A start while i_ready = 0: set o_overrun = 1 (sticky until reset); bits of that window are dropped; stay in HOLD; the rising edge is consumed.
- High after WIN: if i_isgen stays high after a full WIN-cycle window, further high cycles are ignored until i_isgen returns low.
- Width rules:
  - Per-lane counts saturate naturally at WIN (fits CW).
  - o_sum is at most LANES*WIN = 64 (fits SW). No wrap is possible.
- Zero window: impossible, since a start always counts at least 1 cycle, so o_len is never 0 when o_valid = 1.
- i_ready while o_valid = 0: ignored.

Optional Feature:
- SN2BN_WEIGHT_EN defined:
  - Adds input port i_w_sn (1 x LANES, unpacked), weight stream bits.
  - Each lane counts i_sn_bit[k] & i_w_sn[k], giving a unipolar stochastic multiply.
  - o_sum is then the stochastic dot product.
- SN2BN_WEIGHT_EN undefined:
  - Port i_w_sn is absent.
  - Raw i_sn_bit ones are counted.

Test Plan:
- Reset then 16-cycle window, lane bits constant 1,0,1,0 -> o_valid 1 cycle after last bit; o_lane_cnt = {16,0,16,0}; o_sum = 32; o_len = 16.
- i_isgen high for 5 cycles, lane0 pattern 1,1,0,1,1, others 0 -> o_lane_cnt[0] = 4; o_sum = 4; o_len = 5.
- Result held with i_ready = 0 for 10 cycles -> outputs stable; o_valid stays 1. Then i_ready = 1 for 1 cycle -> o_valid = 0 the next cycle.
- New window rising edge in the same cycle as i_ready = 1 -> no bits lost; second result has o_len = 16 and correct counts.
- New window while HOLD and i_ready = 0 -> o_overrun = 1 and stays 1; first result unchanged; no second o_valid.
- Assert i_rst_n_sn2bn low at window cycle 8 -> all outputs 0 immediately. After release, a fresh window counts from 1.
- With SN2BN_WEIGHT_EN: i_sn_bit all 1 and i_w_sn[0] alternating 1,0 over 16 cycles -> o_lane_cnt[0] = 8.

Source files
------------

// File: rtl/sn_to_bn_counter.sv
// Stochastic-to-binary converter: counts ones per lane over one stream window and hands the counts on.
// Optional `SN2BN_WEIGHT_EN adds i_w_sn; each lane then counts i_sn_bit & i_w_sn (stochastic multiply).
module sn_to_bn_counter #(
    parameter int LANES = 4,
    parameter int WIN   = 16,
    parameter int CW    = $clog2(WIN + 1),
    parameter int SW    = $clog2(LANES * WIN + 1)
) (
    input  logic          i_clk_sn2bn,
    input  logic          i_rst_n_sn2bn,
    input  logic          i_isgen,
    input  logic          i_sn_bit [LANES],
`ifdef SN2BN_WEIGHT_EN
    input  logic          i_w_sn [LANES],
`endif
    input  logic          i_ready,
    output logic          o_valid,
    output logic [CW-1:0] o_lane_cnt [LANES],
    output logic [SW-1:0] o_sum,
    output logic [CW-1:0] o_len,
    output logic          o_overrun
);

    localparam logic [CW-1:0] WIN_C   = CW'(WIN);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam bit            ONE_WIN = (WIN == 1);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

    state_t        state;
    logic          isgen_d;
    logic [CW-1:0] acc [LANES];
    logic [CW-1:0] len;

    logic          start;
    logic          bit_c    [LANES];
    logic [CW-1:0] cnt_cand [LANES];
    logic [CW-1:0] len_cand;
    logic [SW-1:0] sum_cand;

    // cnt_cand/len_cand are the counts including this cycle: a fresh start
    // outside ACC, or the running window extended (isgen high) or frozen (isgen low).
    always_comb begin
        start    = i_isgen & ~isgen_d;
        len_cand = ONE_C;
        sum_cand = '0;
        for (int k = 0; k < LANES; k++) begin
`ifdef SN2BN_WEIGHT_EN
            bit_c[k] = i_sn_bit[k] & i_w_sn[k];
`else
            bit_c[k] = i_sn_bit[k];
`endif
            cnt_cand[k] = CW'(bit_c[k]);
            if (state == S_ACC) begin
                cnt_cand[k] = i_isgen ? (acc[k] + CW'(bit_c[k])) : acc[k];
            end
            sum_cand = sum_cand + SW'(cnt_cand[k]);
        end
        if (state == S_ACC) begin
            len_cand = i_isgen ? (len + ONE_C) : len;
        end
    end

    always_ff @(posedge i_clk_sn2bn or negedge i_rst_n_sn2bn) begin
        if (!i_rst_n_sn2bn) begin
            state     <= S_IDLE;
            isgen_d   <= 1'b0;
            len       <= '0;
            o_valid   <= 1'b0;
            o_sum     <= '0;
            o_len     <= '0;
            o_overrun <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                acc[k]        <= '0;
                o_lane_cnt[k] <= '0;
            end
        end else begin
            isgen_d <= i_isgen;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc   <= cnt_cand;
                        len   <= len_cand;
                        state <= S_ACC;
                        if (ONE_WIN) begin
                            o_lane_cnt <= cnt_cand;
                            o_sum      <= sum_cand;
                            o_len      <= len_cand;
                            o_valid    <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end
                end
                S_ACC: begin
                    if (!i_isgen || len_cand == WIN_C) begin
                        o_lane_cnt <= cnt_cand;
                        o_sum      <= sum_cand;
                        o_len      <= len_cand;
                        o_valid    <= 1'b1;
                        state      <= S_HOLD;
                    end else begin
                        acc <= cnt_cand;
                        len <= len_cand;
                    end
                end
                S_HOLD: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= S_IDLE;
                        // A window opening on the accepting cycle keeps its first bits.
                        if (start) begin
                            acc   <= cnt_cand;
                            len   <= len_cand;
                            state <= S_ACC;
                            if (ONE_WIN) begin
                                o_lane_cnt <= cnt_cand;
                                o_sum      <= sum_cand;
                                o_len      <= len_cand;
                                o_valid    <= 1'b1;
                                state      <= S_HOLD;
                            end
                        end
                    end else if (start) begin
                        o_overrun <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sn_to_bn_counter.sv
// Scoreboard bench for sn_to_bn_counter: directed windows push expected results, a monitor checks each new o_valid.
module tb_sn_to_bn_counter;

    localparam int LANES = 4;
    localparam int CW    = 5;
    localparam int SW    = 7;

    logic          clk;
    logic          rst_n;
    logic          isgen;
    logic          sn_bit [LANES];
    logic          w_sn   [LANES];
    logic          ready;
    logic          valid;
    logic [CW-1:0] lane_cnt [LANES];
    logic [SW-1:0] sum;
    logic [CW-1:0] len;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cnt [LANES];
        int sum;
        int len;
    } exp_t;
    exp_t sb [$];

    sn_to_bn_counter dut (
        .i_clk_sn2bn   (clk),
        .i_rst_n_sn2bn (rst_n),
        .i_isgen       (isgen),
        .i_sn_bit      (sn_bit),
`ifdef SN2BN_WEIGHT_EN
        .i_w_sn        (w_sn),
`endif
        .i_ready       (ready),
        .o_valid       (valid),
        .o_lane_cnt    (lane_cnt),
        .o_sum         (sum),
        .o_len         (len),
        .o_overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int c0, input int c1, input int c2, input int c3, input int s, input int l);
        exp_t e;
        e.cnt[0] = c0; e.cnt[1] = c1; e.cnt[2] = c2; e.cnt[3] = c3;
        e.sum = s; e.len = l;
        sb.push_back(e);
    endtask

    // One clock: apply inputs, let the edge take them, sample 1 time unit later.
    task automatic cyc(input logic g, input logic [LANES-1:0] b);
        isgen = g;
        for (int k = 0; k < LANES; k++) sn_bit[k] = b[k];
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, int'(valid), 1);
    endtask

    task automatic accept();
        ready = 1'b1;
        cyc(1'b0, 4'b0000);
        ready = 1'b0;
        chk("valid_drop_after_ready", int'(valid), 0);
    endtask

    // Monitor: every rising o_valid must match the oldest expected result.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (valid && !prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    for (int k = 0; k < LANES; k++) chk($sformatf("lane_cnt[%0d]", k), int'(lane_cnt[k]), e.cnt[k]);
                    chk("sum", int'(sum), e.sum);
                    chk("len", int'(len), e.len);
                end
            end
            prev = valid;
        end
    end

    initial begin
        rst_n = 1'b0;
        isgen = 1'b0;
        ready = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            sn_bit[k] = 1'b0;
            w_sn[k]   = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(valid), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_len", int'(len), 0);
        chk("rst_overrun", int'(overrun), 0);
        for (int k = 0; k < LANES; k++) chk("rst_lane_cnt", int'(lane_cnt[k]), 0);
        rst_n = 1'b1;
        cyc(1'b0, 4'b0000);

        // Full 16-cycle window, lanes 1,0,1,0 constant.
        push(16, 0, 16, 0, 32, 16);
        for (int i = 0; i < 15; i++) cyc(1'b1, 4'b0101);
        chk("valid_before_last_bit", int'(valid), 0);
        cyc(1'b1, 4'b0101);
        chk("valid_latency_full", int'(valid), 1);
        // Held with ready low: outputs must not move.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 4'b0000);
            chk("hold_valid", int'(valid), 1);
            chk("hold_sum", int'(sum), 32);
            chk("hold_len", int'(len), 16);
        end
        accept();

        // Short window closed by isgen low: lane0 1,1,0,1,1.
        push(4, 0, 0, 0, 4, 5);
        cyc(1'b1, 4'b0001);
        cyc(1'b1, 4'b0001);
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0001);
        cyc(1'b1, 4'b0001);
        cyc(1'b0, 4'b0000);
        wait_valid("valid_short");
        accept();

        // Start on the same cycle as ready: second window loses no bits.
        push(16, 16, 16, 16, 64, 16);
        for (int i = 0; i < 16; i++) cyc(1'b1, 4'b1111);
        cyc(1'b0, 4'b0000);
        push(16, 16, 0, 0, 32, 16);
        ready = 1'b1;
        cyc(1'b1, 4'b0011);
        ready = 1'b0;
        chk("valid_low_after_ready_start", int'(valid), 0);
        for (int i = 0; i < 15; i++) cyc(1'b1, 4'b0011);
        chk("valid_back_to_back", int'(valid), 1);
        // Staying high past a full window is ignored, not an overrun.
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b1111);
        cyc(1'b0, 4'b0000);
        chk("no_overrun_high_after_win", int'(overrun), 0);
        chk("held_sum_after_win", int'(sum), 32);
        accept();

        // Overrun: new window while result held with ready low.
        push(0, 0, 0, 3, 3, 3);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b1000);
        cyc(1'b0, 4'b0000);
        wait_valid("valid_pre_overrun");
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'b1111);
        cyc(1'b0, 4'b0000);
        chk("overrun_set", int'(overrun), 1);
        chk("overrun_valid_held", int'(valid), 1);
        chk("overrun_sum_held", int'(sum), 3);
        chk("overrun_len_held", int'(len), 3);
        for (int i = 0; i < 20; i++) cyc(1'b0, 4'b0000);
        chk("overrun_sticky", int'(overrun), 1);
        accept();
        repeat (3) cyc(1'b0, 4'b0000);
        chk("overrun_sticky_after_accept", int'(overrun), 1);
        chk("no_second_valid", int'(valid), 0);

        // Reset at window cycle 8 discards the partial window.
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'b1111);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_sum", int'(sum), 0);
        chk("midrst_len", int'(len), 0);
        chk("midrst_overrun", int'(overrun), 0);
        for (int k = 0; k < LANES; k++) chk("midrst_lane_cnt", int'(lane_cnt[k]), 0);
        isgen = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(0, 0, 2, 0, 2, 2);
        cyc(1'b1, 4'b0100);
        cyc(1'b1, 4'b0100);
        cyc(1'b0, 4'b0000);
        wait_valid("valid_after_reset");
        accept();

`ifdef SN2BN_WEIGHT_EN
        // Weighted: all stream bits 1, lane0 weight alternating 1,0.
        push(8, 16, 16, 16, 56, 16);
        for (int i = 0; i < 16; i++) begin
            w_sn[0] = (i % 2 == 0);
            cyc(1'b1, 4'b1111);
        end
        w_sn[0] = 1'b1;
        cyc(1'b0, 4'b0000);
        wait_valid("valid_weighted");
        accept();
`endif

        repeat (5) cyc(1'b0, 4'b0000);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
